brightness_step_ctrl: RTL and testbench

//  Brightness controller between the two push-button chains (up, down) and the PWM generator.

---
 rtl/brightness_step_ctrl_pkg.sv | 23 ++
 rtl/brightness_step_ctrl_if.sv | 23 ++
 rtl/brightness_step_ctrl_step_timer.sv | 32 +++
 rtl/brightness_step_ctrl.sv | 115 +++++++++++
 tb/tb_brightness_step_ctrl.sv | 200 ++++++++++++++++++++
 5 files changed

// File: rtl/brightness_step_ctrl_pkg.sv
// Shared types and constants for the brightness step controller and the PWM generator.
package brightness_step_ctrl_pkg;

  localparam int unsigned DUTY_W_DEF   = 8;
  localparam int unsigned DUTY_MAX_DEF = (1 << DUTY_W_DEF) - 1;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_UP_HOLD = 3'd1,
    S_UP_RPT  = 3'd2,
    S_DN_HOLD = 3'd3,
    S_DN_RPT  = 3'd4
  } state_t;

  // Timer width large enough for the longer of the two intervals.
  function automatic int unsigned tmr_width(input int unsigned hold_cyc,
                                            input int unsigned repeat_cyc);
    int unsigned m;
    m = (hold_cyc > repeat_cyc) ? hold_cyc : repeat_cyc;
    return $clog2(m);
  endfunction

endpackage

// File: rtl/brightness_step_ctrl_if.sv
// Button-chain inputs and duty/status outputs of the brightness controller.
interface brightness_step_ctrl_if #(
  parameter int unsigned DUTY_W = 8
);
  logic              up_pulse;
  logic              dn_pulse;
  logic              up_level;
  logic              dn_level;
  logic [DUTY_W-1:0] duty_out;
  logic              at_max;
  logic              at_min;
  logic              repeating;

  modport master (
    output up_pulse, dn_pulse, up_level, dn_level,
    input  duty_out, at_max, at_min, repeating
  );

  modport slave (
    input  up_pulse, dn_pulse, up_level, dn_level,
    output duty_out, at_max, at_min, repeating
  );
endinterface

// File: rtl/brightness_step_ctrl_step_timer.sv
// Hold/repeat interval counter with synchronous clear and terminal-count decode.
module brightness_step_ctrl_step_timer
  import brightness_step_ctrl_pkg::*;
#(
  parameter int unsigned HOLD_CYC   = 50_000_000,
  parameter int unsigned REPEAT_CYC = 10_000_000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic sel_hold,
  output logic tc_c
);
  localparam int unsigned TMR_W = tmr_width(HOLD_CYC, REPEAT_CYC);

  logic [TMR_W-1:0] count_q;
  logic [TMR_W-1:0] limit;

  assign limit = sel_hold ? TMR_W'(HOLD_CYC - 1) : TMR_W'(REPEAT_CYC - 1);
  assign tc_c  = (count_q == limit);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else if (clr) begin
      count_q <= '0;
    end else begin
      count_q <= count_q + TMR_W'(1);
    end
  end

endmodule

// File: rtl/brightness_step_ctrl.sv
// Press/auto-repeat brightness controller owning a saturating duty register.
module brightness_step_ctrl
  import brightness_step_ctrl_pkg::*;
#(
  parameter int unsigned DUTY_W     = DUTY_W_DEF,
  parameter int unsigned STEP       = 16,
  parameter int unsigned RESET_DUTY = 128,
  parameter int unsigned HOLD_CYC   = 50_000_000,
  parameter int unsigned REPEAT_CYC = 10_000_000
) (
  input  logic                   clk,
  input  logic                   rst_n,
  brightness_step_ctrl_if.slave  bus
);
  localparam int unsigned DUTY_MAX = (1 << DUTY_W) - 1;

  state_t            state_q, state_d;
  logic [DUTY_W-1:0] duty_q, duty_d;
  logic              at_max_q, at_min_q, rpt_q;
  logic              step_up, step_dn;
  logic              tmr_clr, sel_hold, tc_c;
  logic [DUTY_W:0]   sum_c, diff_c;

  assign sel_hold = (state_q == S_UP_HOLD) || (state_q == S_DN_HOLD);

  brightness_step_ctrl_step_timer #(
    .HOLD_CYC   (HOLD_CYC),
    .REPEAT_CYC (REPEAT_CYC)
  ) u_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr      (tmr_clr),
    .sel_hold (sel_hold),
    .tc_c     (tc_c)
  );

  // Next-state and step decision; any exit or step restarts the timer.
  always_comb begin
    state_d = state_q;
    step_up = 1'b0;
    step_dn = 1'b0;
    tmr_clr = 1'b0;
    case (state_q)
      S_IDLE: begin
        tmr_clr = 1'b1;
        if (bus.up_pulse && !bus.dn_pulse) begin
          step_up = 1'b1;
          state_d = S_UP_HOLD;
        end else if (bus.dn_pulse && !bus.up_pulse) begin
          step_dn = 1'b1;
          state_d = S_DN_HOLD;
        end
      end
      S_UP_HOLD, S_UP_RPT: begin
        if (bus.dn_pulse || !bus.up_level) begin
          state_d = S_IDLE;
          tmr_clr = 1'b1;
        end else if (tc_c) begin
          step_up = 1'b1;
          state_d = S_UP_RPT;
          tmr_clr = 1'b1;
        end
      end
      S_DN_HOLD, S_DN_RPT: begin
        if (bus.up_pulse || !bus.dn_level) begin
          state_d = S_IDLE;
          tmr_clr = 1'b1;
        end else if (tc_c) begin
          step_dn = 1'b1;
          state_d = S_DN_RPT;
          tmr_clr = 1'b1;
        end
      end
      default: begin
        state_d = S_IDLE;
        tmr_clr = 1'b1;
      end
    endcase
  end

  // Saturating duty datapath, one extra bit to catch overflow/borrow.
  always_comb begin
    sum_c  = {1'b0, duty_q} + (DUTY_W+1)'(STEP);
    diff_c = {1'b0, duty_q} - (DUTY_W+1)'(STEP);
    duty_d = duty_q;
    if (step_up) begin
      duty_d = (sum_c > (DUTY_W+1)'(DUTY_MAX)) ? DUTY_W'(DUTY_MAX) : sum_c[DUTY_W-1:0];
    end else if (step_dn) begin
      duty_d = diff_c[DUTY_W] ? '0 : diff_c[DUTY_W-1:0];
    end
  end

  // Flags are registered from the next duty so they track duty_out without lag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      duty_q   <= DUTY_W'(RESET_DUTY);
      at_max_q <= (RESET_DUTY == DUTY_MAX);
      at_min_q <= (RESET_DUTY == 0);
      rpt_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      duty_q   <= duty_d;
      at_max_q <= (duty_d == DUTY_W'(DUTY_MAX));
      at_min_q <= (duty_d == '0);
      rpt_q    <= (state_d == S_UP_RPT) || (state_d == S_DN_RPT);
    end
  end

  assign bus.duty_out  = duty_q;
  assign bus.at_max    = at_max_q;
  assign bus.at_min    = at_min_q;
  assign bus.repeating = rpt_q;

endmodule

// File: tb/tb_brightness_step_ctrl.sv
// Directed bench for brightness_step_ctrl with short hold/repeat intervals.
module tb_brightness_step_ctrl;

  logic clk;
  logic rst_n;
  int   n_vec;
  int   n_err;

  brightness_step_ctrl_if #(.DUTY_W(8)) bus ();

  brightness_step_ctrl #(
    .DUTY_W     (8),
    .STEP       (16),
    .RESET_DUTY (128),
    .HOLD_CYC   (8),
    .REPEAT_CYC (4)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // One clock edge; inputs are driven and outputs sampled 1 time unit after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic do_reset();
    rst_n        = 1'b0;
    bus.up_pulse = 1'b0;
    bus.dn_pulse = 1'b0;
    bus.up_level = 1'b0;
    bus.dn_level = 1'b0;
    ticks(2);
    rst_n = 1'b1;
    tick();
  endtask

  // Single short press: pulse plus a one-cycle level, then release.
  task automatic press(input logic up);
    bus.up_pulse = up;
    bus.up_level = up;
    bus.dn_pulse = !up;
    bus.dn_level = !up;
    tick();
    bus.up_pulse = 1'b0;
    bus.dn_pulse = 1'b0;
    bus.up_level = 1'b0;
    bus.dn_level = 1'b0;
    tick();
  endtask

  // Press up and keep level high for n edges after the press edge.
  task automatic hold_up(input int n);
    bus.up_pulse = 1'b1;
    bus.up_level = 1'b1;
    tick();
    bus.up_pulse = 1'b0;
    ticks(n);
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    #2;

    // Reset values
    do_reset();
    check_eq("rst_duty", 32'(bus.duty_out), 128);
    check_eq("rst_at_max", 32'(bus.at_max), 0);
    check_eq("rst_at_min", 32'(bus.at_min), 0);
    check_eq("rst_rpt", 32'(bus.repeating), 0);

    // Single short press
    bus.up_pulse = 1'b1;
    bus.up_level = 1'b1;
    tick();
    bus.up_pulse = 1'b0;
    bus.up_level = 1'b0;
    check_eq("press_duty", 32'(bus.duty_out), 144);
    ticks(5);
    check_eq("press_stay", 32'(bus.duty_out), 144);
    check_eq("press_rpt", 32'(bus.repeating), 0);

    // Held press: steps visible in cycles 1, 9, 13, 17
    do_reset();
    bus.up_pulse = 1'b1;
    bus.up_level = 1'b1;
    for (int e = 0; e < 20; e++) begin
      tick();
      bus.up_pulse = 1'b0;
      case (e + 1)
        1:  check_eq("hold_c1", 32'(bus.duty_out), 144);
        8:  check_eq("hold_c8", 32'(bus.duty_out), 144);
        9:  check_eq("hold_c9", 32'(bus.duty_out), 160);
        12: check_eq("hold_c12", 32'(bus.duty_out), 160);
        13: check_eq("hold_c13", 32'(bus.duty_out), 176);
        17: check_eq("hold_c17", 32'(bus.duty_out), 192);
        default: ;
      endcase
      if (e + 1 == 8) check_eq("hold_rpt_c8", 32'(bus.repeating), 0);
      if (e + 1 == 9) check_eq("hold_rpt_c9", 32'(bus.repeating), 1);
    end
    bus.up_level = 1'b0;
    tick();
    check_eq("hold_drop_rpt", 32'(bus.repeating), 0);
    ticks(10);
    check_eq("hold_drop_duty", 32'(bus.duty_out), 192);

    // Upper clamp from 240
    press(1'b1);
    press(1'b1);
    press(1'b1);
    check_eq("pre_clamp", 32'(bus.duty_out), 240);
    check_eq("pre_clamp_max", 32'(bus.at_max), 0);
    hold_up(0);
    check_eq("clamp_hi", 32'(bus.duty_out), 255);
    check_eq("clamp_at_max", 32'(bus.at_max), 1);
    ticks(14);
    check_eq("clamp_hi_rpt", 32'(bus.duty_out), 255);
    check_eq("clamp_hi_rptflag", 32'(bus.repeating), 1);
    bus.up_level = 1'b0;
    tick();

    // Lower clamp via single down presses
    for (int i = 0; i < 15; i++) press(1'b0);
    check_eq("dn15", 32'(bus.duty_out), 15);
    check_eq("dn15_min", 32'(bus.at_min), 0);
    press(1'b0);
    check_eq("dn16", 32'(bus.duty_out), 0);
    check_eq("dn16_min", 32'(bus.at_min), 1);
    check_eq("dn16_max", 32'(bus.at_max), 0);
    press(1'b0);
    check_eq("dn17", 32'(bus.duty_out), 0);

    // Simultaneous pulses, then opposite pulse during repeat
    do_reset();
    bus.up_pulse = 1'b1;
    bus.dn_pulse = 1'b1;
    bus.up_level = 1'b1;
    bus.dn_level = 1'b1;
    tick();
    bus.up_pulse = 1'b0;
    bus.dn_pulse = 1'b0;
    check_eq("both_duty", 32'(bus.duty_out), 128);
    ticks(10);
    check_eq("both_hold", 32'(bus.duty_out), 128);
    bus.dn_level = 1'b0;
    bus.up_level = 1'b0;
    tick();
    hold_up(8);
    check_eq("opp_pre", 32'(bus.duty_out), 160);
    check_eq("opp_pre_rpt", 32'(bus.repeating), 1);
    bus.dn_pulse = 1'b1;
    tick();
    bus.dn_pulse = 1'b0;
    check_eq("opp_duty", 32'(bus.duty_out), 160);
    check_eq("opp_rpt", 32'(bus.repeating), 0);
    ticks(12);
    check_eq("opp_level_no_step", 32'(bus.duty_out), 160);
    bus.up_level = 1'b0;
    tick();

    // Async reset mid-repeat
    do_reset();
    hold_up(16);
    check_eq("mid_pre", 32'(bus.duty_out), 192);
    rst_n = 1'b0;
    #1;
    check_eq("mid_rst_duty", 32'(bus.duty_out), 128);
    check_eq("mid_rst_rpt", 32'(bus.repeating), 0);
    ticks(2);
    rst_n = 1'b1;
    ticks(20);
    check_eq("post_rst_duty", 32'(bus.duty_out), 128);
    check_eq("post_rst_rpt", 32'(bus.repeating), 0);
    bus.up_level = 1'b0;
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
